ef_uart_tx_arbiter: RTL and testbench
=====================================

// Module: ef_uart_tx_arbiter
// PURPOSE
//  Shares one EF_UART transmit path (TX FIFO write port, as written via TXDATA) among N_REQ byte-stream requesters.
//  Round-robin arbitration at packet granularity: a granted requester owns the UART until it sends its last byte.
//  A stall timeout reclaims the UART from a requester that goes silent mid-packet.
//  Sits between on-chip message sources (CPU mailbox, debug, log engines) and the UART TX FIFO.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  DW     8   byte width; matches UART data width
//  TO_W   16  width of stall-timeout counter
// PORTS
//  HCLK        in   1         clock
//  HRESETn     in   1         asynchronous active-low reset
//  en          in   1         arbiter enable; 0 blocks new grants
//  timeout     in   TO_W      stall limit in cycles; 0 disables timeout
//  req_valid   in   N_REQ     per-requester byte valid
//  req_data    in   N_REQ*DW  per-requester byte; requester i uses bits [i*DW +: DW]
//  req_last    in   N_REQ     byte is the last of its packet
//  req_ready   out  N_REQ     byte accepted when req_valid[i] & req_ready[i]
//  fifo_wdata  out  DW        byte to UART TX FIFO
//  fifo_wr     out  1         TX FIFO write strobe
//  fifo_full   in   1         TX FIFO full
//  grant       out  N_REQ     one-hot current owner; 0 when idle
//  busy        out  1         1 while a grant is held
//  to_evt      out  1         one-cycle pulse on timeout release
//  to_src      out  clog2(N)  index of the requester last released by timeout
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=N_REQ-1 so requester 0 wins first. All outputs 0.
//  States: IDLE, GRANT. grant, busy, to_evt and to_src are registered.
//  IDLE: if en & |req_valid, pick the first valid index scanning rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
//   Load grant. Go to GRANT next cycle. Otherwise stay.
//  GRANT, index g:
//   req_ready[g] = ~fifo_full (combinational). Other req_ready bits are 0.
//   fifo_wr = req_valid[g] & ~fifo_full. fifo_wdata = req_data[g] (combinational mux).
//   Transfer = fifo_wr. Transfer with req_last[g] -> IDLE next cycle, rr_ptr<=g, grant<=0.
//  Latency: first byte can be written the cycle after the IDLE decision.
//   A one-cycle idle bubble separates packets; it is required.
//  Timeout: stall counter cleared on entry to GRANT and on every transfer.
//   Increments only when ~req_valid[g]. A cycle stalled by fifo_full is not counted.
//   Counter reaches timeout (timeout!=0) -> release to IDLE, rr_ptr<=g, to_evt=1 for one cycle, to_src<=g.
//   The counter saturates; it never wraps.
//  en deasserted during GRANT: the current packet completes normally. No abort.
//  en=0 in IDLE: no grant is issued; req_ready stays 0.
//  timeout changed mid-packet: the new value takes effect immediately.
//   If counter >= new nonzero value, release on the next cycle.
//  Requester dropping req_valid with no last: it keeps the grant until the timeout fires (forever if timeout=0).
//  HRESETn asserted mid-packet: immediate return to the reset state. A partially written packet is not recovered.
//  grant is always one-hot or zero. fifo_wr never asserts while fifo_full=1.
// TESTING
//  1 Single requester 0 sends 3 bytes A5,5A,C3 with last on C3, fifo_full=0:
//    fifo_wr pulses with bytes in order; grant=0001; busy drops the cycle after C3.
//  2 All four requesters hold 2-byte packets:
//    grant order 0,1,2,3,0; each packet is contiguous; one idle cycle between packets.
//  3 Requester 1 mid-packet, fifo_full held 50 cycles, timeout=10:
//    no release; fifo_wr=0 while full; transfer resumes when not full.
//  4 Requester 2 sends one byte, then drops valid with no last, timeout=8:
//    released 8 cycles later; to_evt pulses once; to_src=2; next grant goes to 3.
//  5 en=0 with all req_valid=1 -> no grant. Set en=1 -> grant=0001. Drop en mid-packet -> packet completes, then idle.
//  6 Assert HRESETn low mid-packet of requester 3 -> all outputs 0 asynchronously.
//    After release, requester 0 wins first.

Source files
------------

// File: rtl/ef_uart_tx_arbiter_if.sv
// Requester byte streams and UART TX FIFO write port shared through the arbiter.
// The master modport is the arbiter's view; slave is the view of the sources and FIFO.
interface ef_uart_tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 8
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    req_last;
   logic [N_REQ-1:0]    req_ready;
   logic [DW-1:0]       fifo_wdata;
   logic                fifo_wr;
   logic                fifo_full;

   modport master (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wdata, fifo_wr
   );

   modport slave (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wdata, fifo_wr
   );
endinterface

// File: rtl/ef_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port
// among N_REQ byte-stream requesters, with a stall timeout that reclaims the
// UART from a requester that goes silent mid-packet.
module ef_uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int DW    = 8,
   parameter int TO_W  = 16
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic                       en,
   input  logic [TO_W-1:0]            timeout,
   ef_uart_tx_arbiter_if.master       bus,
   output logic [N_REQ-1:0]           grant,
   output logic                       busy,
   output logic                       to_evt,
   output logic [$clog2(N_REQ)-1:0]   to_src
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t           state_q, state_nxt;
   logic [IW-1:0]    g_q, g_nxt;
   logic [IW-1:0]    rr_q, rr_nxt;
   logic [TO_W-1:0]  cnt_q, cnt_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic             busy_nxt;
   logic             to_evt_nxt;
   logic [IW-1:0]    to_src_nxt;
   logic             xfer;

   // First valid requester strictly after ptr, scanning upward modulo N_REQ.
   function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] ptr,
                                             input logic [N_REQ-1:0] vld);
      logic [IW-1:0] sel;
      logic          hit;
      int            j;
      sel = ptr;
      hit = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!hit && vld[j]) begin
            hit = 1'b1;
            sel = IW'(j);
         end
      end
      return sel;
   endfunction

   // Stall counter increment that holds at all-ones instead of wrapping.
   function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
      return (c == {TO_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   // A byte moves only from the owner, and never into a full FIFO.
   assign xfer           = (state_q == GRANT) & bus.req_valid[g_q] & ~bus.fifo_full;
   assign bus.fifo_wr    = xfer;
   assign bus.req_ready  = grant & {N_REQ{~bus.fifo_full}};
   assign bus.fifo_wdata = busy ? bus.req_data[int'(g_q)*DW +: DW] : '0;

   // Next-state, grant selection, stall counting and release decisions.
   always_comb begin
      state_nxt  = state_q;
      g_nxt      = g_q;
      rr_nxt     = rr_q;
      cnt_nxt    = cnt_q;
      grant_nxt  = grant;
      busy_nxt   = busy;
      to_evt_nxt = 1'b0;
      to_src_nxt = to_src;
      case (state_q)
         IDLE: begin
            if (en && (|bus.req_valid)) begin
               g_nxt     = rr_pick(rr_q, bus.req_valid);
               grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << g_nxt;
               busy_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // FIFO-full cycles hold the counter: the owner is not silent then.
            if (xfer) begin
               cnt_nxt = '0;
            end else if (!bus.req_valid[g_q]) begin
               cnt_nxt = sat_inc(cnt_q);
            end
            if (xfer && bus.req_last[g_q]) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               rr_nxt    = g_q;
            end else if ((timeout != '0) && (cnt_nxt >= timeout)) begin
               state_nxt  = IDLE;
               grant_nxt  = '0;
               busy_nxt   = 1'b0;
               rr_nxt     = g_q;
               to_evt_nxt = 1'b1;
               to_src_nxt = g_q;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; rr_q starts at the top so requester 0 wins first.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         g_q     <= '0;
         rr_q    <= IW'(N_REQ - 1);
         cnt_q   <= '0;
         grant   <= '0;
         busy    <= 1'b0;
         to_evt  <= 1'b0;
         to_src  <= '0;
      end else begin
         state_q <= state_nxt;
         g_q     <= g_nxt;
         rr_q    <= rr_nxt;
         cnt_q   <= cnt_nxt;
         grant   <= grant_nxt;
         busy    <= busy_nxt;
         to_evt  <= to_evt_nxt;
         to_src  <= to_src_nxt;
      end
   end

endmodule

// File: tb/tb_ef_uart_tx_arbiter.sv
// Directed bench for ef_uart_tx_arbiter: one task per scenario with inline checks.
module tb_ef_uart_tx_arbiter;

   logic        HCLK;
   logic        HRESETn;
   logic        en;
   logic [15:0] timeout;
   logic [3:0]  grant;
   logic        busy;
   logic        to_evt;
   logic [1:0]  to_src;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ef_uart_tx_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

   ef_uart_tx_arbiter #(.N_REQ(4), .DW(8), .TO_W(16)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .en      (en),
      .timeout (timeout),
      .bus     (bus.master),
      .grant   (grant),
      .busy    (busy),
      .to_evt  (to_evt),
      .to_src  (to_src)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;
   endtask

   task automatic apply_reset();
      HRESETn = 1'b0;
      tick();
      tick();
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      en = 1'b0;
      timeout = '0;
      HRESETn = 1'b0;
      tick();
      total_cnt++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (to_evt !== 1'b0 || to_src !== 2'd0) $display("FAIL rst_to: got evt=%b src=%0d want 0/0", to_evt, to_src); else pass_cnt++;
      total_cnt++; if (bus.fifo_wr !== 1'b0 || bus.req_ready !== 4'b0) $display("FAIL rst_wr_ready: got wr=%b rdy=%b want 0/0000", bus.fifo_wr, bus.req_ready); else pass_cnt++;
      HRESETn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      en = 1'b1;
      timeout = '0;
      bus.req_valid = 4'b0001;
      bus.req_data[7:0] = 8'hA5;
      #1;
      total_cnt++; if (grant !== 4'b0000 || bus.fifo_wr !== 1'b0) $display("FAIL t1_idle: got grant=%b wr=%b want 0000/0", grant, bus.fifo_wr); else pass_cnt++;
      tick();
      total_cnt++; if (grant !== 4'b0001 || busy !== 1'b1) $display("FAIL t1_grant: got grant=%b busy=%b want 0001/1", grant, busy); else pass_cnt++;
      total_cnt++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'hA5) $display("FAIL t1_b0: got wr=%b data=%h want 1/a5", bus.fifo_wr, bus.fifo_wdata); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 4'b0001) $display("FAIL t1_ready: got %b want 0001", bus.req_ready); else pass_cnt++;
      tick();
      bus.req_data[7:0] = 8'h5A;
      #1;
      total_cnt++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h5A) $display("FAIL t1_b1: got wr=%b data=%h want 1/5a", bus.fifo_wr, bus.fifo_wdata); else pass_cnt++;
      tick();
      bus.req_data[7:0] = 8'hC3;
      bus.req_last = 4'b0001;
      #1;
      total_cnt++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'hC3 || busy !== 1'b1) $display("FAIL t1_b2: got wr=%b data=%h busy=%b want 1/c3/1", bus.fifo_wr, bus.fifo_wdata, busy); else pass_cnt++;
      tick();
      clear_inputs();
      #1;
      total_cnt++; if (busy !== 1'b0 || grant !== 4'b0000 || bus.fifo_wr !== 1'b0) $display("FAIL t1_done: got busy=%b grant=%b wr=%b want 0/0000/0", busy, grant, bus.fifo_wr); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int       exp_g [16] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0, -1};
      int       lim   [4]  = '{4, 2, 2, 2};
      int       sent  [4]  = '{0, 0, 0, 0};
      logic [3:0] eg;
      logic [7:0] eb;
      apply_reset();
      en = 1'b1;
      timeout = '0;
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]       = (sent[i] < lim[i]);
            bus.req_data[i*8 +: 8] = 8'(8'h10 * i + sent[i]);
            bus.req_last[i]        = (sent[i] % 2) == 1;
         end
         #1;
         eg = (exp_g[c] < 0) ? 4'b0000 : 4'(1 << exp_g[c]);
         total_cnt++; if (grant !== eg || bus.fifo_wr !== (exp_g[c] >= 0)) $display("FAIL t2_cyc%0d: got grant=%b wr=%b want %b/%b", c, grant, bus.fifo_wr, eg, exp_g[c] >= 0); else pass_cnt++;
         if (exp_g[c] >= 0) begin
            eb = 8'(8'h10 * exp_g[c] + sent[exp_g[c]]);
            total_cnt++; if (bus.fifo_wdata !== eb) $display("FAIL t2_data%0d: got %h want %h", c, bus.fifo_wdata, eb); else pass_cnt++;
            sent[exp_g[c]]++;
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_fifo_full_stall();
      timeout = 16'd10;
      bus.req_valid = 4'b0010;
      bus.req_data[15:8] = 8'h11;
      #1;
      tick();
      total_cnt++; if (grant !== 4'b0010 || bus.fifo_wr !== 1'b1) $display("FAIL t3_grant: got grant=%b wr=%b want 0010/1", grant, bus.fifo_wr); else pass_cnt++;
      tick();
      bus.req_data[15:8] = 8'h22;
      bus.fifo_full = 1'b1;
      for (int s = 0; s < 50; s++) begin
         #1;
         total_cnt++; if (bus.fifo_wr !== 1'b0 || bus.req_ready !== 4'b0000 || grant !== 4'b0010 || to_evt !== 1'b0) $display("FAIL t3_full%0d: got wr=%b rdy=%b grant=%b evt=%b want 0/0000/0010/0", s, bus.fifo_wr, bus.req_ready, grant, to_evt); else pass_cnt++;
         tick();
      end
      bus.fifo_full = 1'b0;
      bus.req_last = 4'b0010;
      #1;
      total_cnt++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h22 || bus.req_ready !== 4'b0010) $display("FAIL t3_resume: got wr=%b data=%h rdy=%b want 1/22/0010", bus.fifo_wr, bus.fifo_wdata, bus.req_ready); else pass_cnt++;
      tick();
      clear_inputs();
      #1;
      total_cnt++; if (busy !== 1'b0 || to_evt !== 1'b0) $display("FAIL t3_done: got busy=%b evt=%b want 0/0", busy, to_evt); else pass_cnt++;
   endtask

   task automatic test_timeout();
      timeout = 16'd8;
      bus.req_valid = 4'b0100;
      bus.req_data[23:16] = 8'h2A;
      #1;
      tick();
      total_cnt++; if (grant !== 4'b0100 || bus.fifo_wdata !== 8'h2A) $display("FAIL t4_grant: got grant=%b data=%h want 0100/2a", grant, bus.fifo_wdata); else pass_cnt++;
      tick();
      bus.req_valid = 4'b1001;
      bus.req_data[31:24] = 8'h3C;
      for (int s = 0; s < 8; s++) begin
         #1;
         total_cnt++; if (grant !== 4'b0100 || to_evt !== 1'b0 || bus.fifo_wr !== 1'b0) $display("FAIL t4_stall%0d: got grant=%b evt=%b wr=%b want 0100/0/0", s, grant, to_evt, bus.fifo_wr); else pass_cnt++;
         tick();
      end
      total_cnt++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL t4_release: got grant=%b busy=%b want 0000/0", grant, busy); else pass_cnt++;
      total_cnt++; if (to_evt !== 1'b1 || to_src !== 2'd2) $display("FAIL t4_evt: got evt=%b src=%0d want 1/2", to_evt, to_src); else pass_cnt++;
      tick();
      total_cnt++; if (grant !== 4'b1000 || to_evt !== 1'b0 || to_src !== 2'd2) $display("FAIL t4_next: got grant=%b evt=%b src=%0d want 1000/0/2", grant, to_evt, to_src); else pass_cnt++;
      bus.req_last = 4'b1000;
      #1;
      total_cnt++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h3C) $display("FAIL t4_r3: got wr=%b data=%h want 1/3c", bus.fifo_wr, bus.fifo_wdata); else pass_cnt++;
      tick();
      clear_inputs();
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL t4_done: got busy=%b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_enable();
      timeout = '0;
      en = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_data = 32'h44332211;
      #1;
      total_cnt++; if (grant !== 4'b0000 || bus.req_ready !== 4'b0000) $display("FAIL t5_off0: got grant=%b rdy=%b want 0000/0000", grant, bus.req_ready); else pass_cnt++;
      tick();
      tick();
      total_cnt++; if (grant !== 4'b0000 || busy !== 1'b0 || bus.fifo_wr !== 1'b0) $display("FAIL t5_off1: got grant=%b busy=%b wr=%b want 0000/0/0", grant, busy, bus.fifo_wr); else pass_cnt++;
      en = 1'b1;
      tick();
      total_cnt++; if (grant !== 4'b0001 || bus.fifo_wdata !== 8'h11) $display("FAIL t5_on: got grant=%b data=%h want 0001/11", grant, bus.fifo_wdata); else pass_cnt++;
      en = 1'b0;
      tick();
      bus.req_last = 4'b0001;
      bus.req_data[7:0] = 8'h12;
      #1;
      total_cnt++; if (grant !== 4'b0001 || bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h12) $display("FAIL t5_complete: got grant=%b wr=%b data=%h want 0001/1/12", grant, bus.fifo_wr, bus.fifo_wdata); else pass_cnt++;
      tick();
      bus.req_last = 4'b0000;
      tick();
      total_cnt++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL t5_idle: got grant=%b busy=%b want 0000/0", grant, busy); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_async_reset();
      en = 1'b1;
      timeout = 16'd8;
      bus.req_valid = 4'b1000;
      bus.req_data[31:24] = 8'h77;
      #1;
      tick();
      tick();
      total_cnt++; if (grant !== 4'b1000 || busy !== 1'b1) $display("FAIL t6_grant: got grant=%b busy=%b want 1000/1", grant, busy); else pass_cnt++;
      #2;
      HRESETn = 1'b0;
      #1;
      total_cnt++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL t6_async: got grant=%b busy=%b want 0000/0", grant, busy); else pass_cnt++;
      total_cnt++; if (bus.fifo_wr !== 1'b0 || bus.req_ready !== 4'b0000 || bus.fifo_wdata !== 8'h00) $display("FAIL t6_async_bus: got wr=%b rdy=%b data=%h want 0/0000/00", bus.fifo_wr, bus.req_ready, bus.fifo_wdata); else pass_cnt++;
      total_cnt++; if (to_evt !== 1'b0 || to_src !== 2'd0) $display("FAIL t6_async_to: got evt=%b src=%0d want 0/0", to_evt, to_src); else pass_cnt++;
      tick();
      HRESETn = 1'b1;
      bus.req_valid = 4'b1111;
      #1;
      total_cnt++; if (grant !== 4'b0000) $display("FAIL t6_post_idle: got %b want 0000", grant); else pass_cnt++;
      tick();
      total_cnt++; if (grant !== 4'b0001) $display("FAIL t6_first: got %b want 0001", grant); else pass_cnt++;
      clear_inputs();
   endtask

   initial begin
      HRESETn = 1'b0;
      en = 1'b0;
      timeout = '0;
      clear_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_fifo_full_stall();
      test_timeout();
      test_enable();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
